// File: rtl/exec_rsv_station_ooo.sv
// Reservation station for one execution unit: holds up to DEPTH instructions,
// captures operands from the CDB and issues the oldest ready entry.
module exec_rsv_station_ooo #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int CTRL_W = 12,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_disp_valid,
    output logic              o_disp_ready,
    input  logic [CTRL_W-1:0] i_disp_ctrl,
    input  logic [XLEN-1:0]   i_disp_rs1_data,
    input  logic              i_disp_rs1_rdy,
    input  logic [TAG_W-1:0]  i_disp_rs1_tag,
    input  logic [XLEN-1:0]   i_disp_rs2_data,
    input  logic              i_disp_rs2_rdy,
    input  logic [TAG_W-1:0]  i_disp_rs2_tag,
    input  logic [TAG_W-1:0]  i_disp_rd_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [XLEN-1:0]   i_cdb_data,
    output logic              o_iss_valid,
    input  logic              i_iss_ready,
    output logic [CTRL_W-1:0] o_iss_ctrl,
    output logic [XLEN-1:0]   o_iss_rs1_data,
    output logic [XLEN-1:0]   o_iss_rs2_data,
    output logic [TAG_W-1:0]  o_iss_rd_tag,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DEPTH-1:0]  valid_q;
    logic [CTRL_W-1:0] ctrl_q     [DEPTH];
    logic [XLEN-1:0]   rs1_data_q [DEPTH];
    logic [DEPTH-1:0]  rs1_rdy_q;
    logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
    logic [XLEN-1:0]   rs2_data_q [DEPTH];
    logic [DEPTH-1:0]  rs2_rdy_q;
    logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
    logic [TAG_W-1:0]  rd_tag_q   [DEPTH];
    // age_q[i][j] = 1 : entry i is older than entry j
    logic [DEPTH-1:0]  age_q      [DEPTH];

    logic [DEPTH-1:0]  ready;
    logic              any_ready;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  alloc_idx;
    logic [CNT_W-1:0]  count;
    logic              disp_ready;
    logic              disp_fire;
    logic              iss_fire;
    logic              byp1;
    logic              byp2;

    assign ready = valid_q & rs1_rdy_q & rs2_rdy_q;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // The oldest ready entry is the one no other ready entry is older than.
    always_comb begin
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age_q[j][i]) blocked = 1'b1;
            end
            if (ready[i] && !blocked && !any_ready) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign disp_ready = (count != CNT_W'(DEPTH));
    assign disp_fire  = i_disp_valid & disp_ready & ~i_flush;
    assign o_iss_valid = any_ready & ~i_flush;
    assign iss_fire   = o_iss_valid & i_iss_ready;
    assign byp1 = i_cdb_valid & ~i_disp_rs1_rdy & (i_cdb_tag == i_disp_rs1_tag);
    assign byp2 = i_cdb_valid & ~i_disp_rs2_rdy & (i_cdb_tag == i_disp_rs2_tag);

    assign o_disp_ready   = disp_ready;
    assign o_count        = count;
    assign o_empty        = (count == '0);
    assign o_iss_ctrl     = o_iss_valid ? ctrl_q[sel_idx]     : '0;
    assign o_iss_rs1_data = o_iss_valid ? rs1_data_q[sel_idx] : '0;
    assign o_iss_rs2_data = o_iss_valid ? rs2_data_q[sel_idx] : '0;
    assign o_iss_rd_tag   = o_iss_valid ? rd_tag_q[sel_idx]   : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    valid_q[gi]    <= 1'b0;
                    ctrl_q[gi]     <= '0;
                    rs1_data_q[gi] <= '0;
                    rs1_rdy_q[gi]  <= 1'b0;
                    rs1_tag_q[gi]  <= '0;
                    rs2_data_q[gi] <= '0;
                    rs2_rdy_q[gi]  <= 1'b0;
                    rs2_tag_q[gi]  <= '0;
                    rd_tag_q[gi]   <= '0;
                    age_q[gi]      <= '0;
                end else if (i_flush) begin
                    valid_q[gi] <= 1'b0;
                    age_q[gi]   <= '0;
                end else if (disp_fire && alloc_idx == IDX_W'(gi)) begin
                    valid_q[gi]    <= 1'b1;
                    ctrl_q[gi]     <= i_disp_ctrl;
                    rs1_data_q[gi] <= byp1 ? i_cdb_data : i_disp_rs1_data;
                    rs1_rdy_q[gi]  <= i_disp_rs1_rdy | byp1;
                    rs1_tag_q[gi]  <= i_disp_rs1_tag;
                    rs2_data_q[gi] <= byp2 ? i_cdb_data : i_disp_rs2_data;
                    rs2_rdy_q[gi]  <= i_disp_rs2_rdy | byp2;
                    rs2_tag_q[gi]  <= i_disp_rs2_tag;
                    rd_tag_q[gi]   <= i_disp_rd_tag;
                    age_q[gi]      <= '0;
                end else if (iss_fire && sel_idx == IDX_W'(gi)) begin
                    valid_q[gi] <= 1'b0;
                    age_q[gi]   <= '0;
                end else if (valid_q[gi]) begin
                    if (i_cdb_valid && !rs1_rdy_q[gi] && rs1_tag_q[gi] == i_cdb_tag) begin
                        rs1_data_q[gi] <= i_cdb_data;
                        rs1_rdy_q[gi]  <= 1'b1;
                    end
                    if (i_cdb_valid && !rs2_rdy_q[gi] && rs2_tag_q[gi] == i_cdb_tag) begin
                        rs2_data_q[gi] <= i_cdb_data;
                        rs2_rdy_q[gi]  <= 1'b1;
                    end
                    // Drop the column of an issuing entry, mark a new arrival as younger.
                    for (int j = 0; j < DEPTH; j++) begin
                        if (iss_fire && sel_idx == IDX_W'(j))
                            age_q[gi][j] <= 1'b0;
                        else if (disp_fire && alloc_idx == IDX_W'(j))
                            age_q[gi][j] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
